alu_muldiv_seq: RTL
===================

// Module: alu_muldiv_seq
// PURPOSE
//  Registered, parametrised EX-stage ALU with an iterative multiply/divide unit and HI/LO registers.
//  Executes the existing logic/shift/add ops in 1 cycle and MULTU/DIVU in WIDTH cycles.
//  Uses a start/busy/done handshake so the pipeline hazard unit can stall while busy=1.
// PARAMETERS
//  WIDTH    32  operand/result width in bits; must be >=4
//  SHAMT_W  5   shift-amount width; must equal clog2(WIDTH)
// PORTS
//  clk           in   1        clock; all state changes on the rising edge
//  reset         in   1        reset: synchronous, active-low
//  start         in   1        accept op/operands; sampled only while busy=0
//  ALUOperation  in   4        opcode, see BEHAVIOUR
//  A, B          in   WIDTH    operands (B is the shift source)
//  Shamt         in   SHAMT_W  shift amount
//  busy          out  1        high while an iterative op is in flight
//  done          out  1        one-cycle pulse: ALUResult/Zero/Hi/Lo updated this cycle
//  ALUResult     out  WIDTH    registered result
//  Zero          out  1        registered (ALUResult==0), updated together with ALUResult
//  Hi, Lo        out  WIDTH    HI/LO registers
//  div_by_zero   out  1        set with done when a divide had B==0; cleared on the next done
// BEHAVIOUR
//  Reset (reset==0 at an edge): state=IDLE; busy, done, Zero, div_by_zero, ALUResult, Hi, Lo = 0.
//   Mid-operation reset aborts the op with no partial result.
//  Opcodes: AND 0000, OR 0001, NOR 0010, ADD 0011 (wraps mod 2^WIDTH), SLL 0100 (B<<Shamt),
//   SRL 0101 (B>>Shamt, logical), ORI 0111 (A|B), LUI 1000 ({B[WIDTH/2-1:0], WIDTH/2 zeros}),
//   SUB 1001 (wraps), MULTU 1010, DIVU 1011, MFHI 1100 (ALUResult=Hi), MFLO 1101 (ALUResult=Lo).
//   Any other opcode is a 1-cycle op with ALUResult=0, Zero=1.
//  FSM: IDLE, MUL, DIV (plus FIX when the macro is enabled); busy = (state!=IDLE).
//  Single-cycle op: start at edge N -> ALUResult/Zero loaded at edge N, done=1 for the cycle after edge N.
//  MULTU: operands latched at edge N; shift-add, one bit per edge; at edge N+WIDTH {Hi,Lo}=A*B,
//   ALUResult=Lo, done=1, state=IDLE. busy is high for exactly WIDTH cycles.
//  DIVU: restoring, one quotient bit per edge; at edge N+WIDTH Lo=A/B, Hi=A%B, ALUResult=Lo.
//  DIVU with B==0: no iteration; at edge N Lo=all-ones, Hi=A, ALUResult=Lo, div_by_zero=1, done=1.
//  Hi/Lo change only on MUL/DIV completion or reset; MFHI/MFLO do not modify them.
//  start while busy=1 is ignored; the in-flight op is unaffected.
//  The done cycle has busy=0; a start in that cycle is accepted (back-to-back, no bubble).
//  Between done pulses ALUResult, Zero, Hi, Lo and div_by_zero hold their values; done is low.
//  Operands and opcode are captured at start; later changes to A/B/ALUOperation are don't-care.
// CONFIGURATION
//  ALU_SIGNED_MULDIV_EN defined: adds MULT 1110 and DIV 1111 (two's complement).
//   Magnitudes feed the unsigned core, then state FIX applies the sign for one extra cycle
//   (latency WIDTH+1). Quotient sign = sign(A)^sign(B); remainder takes the sign of A.
//   Signed DIV with B==0 behaves as DIVU with B==0.
//  Not defined: 1110/1111 are unknown opcodes (1 cycle, result 0); FIX state and sign logic absent.
// TESTING (WIDTH=32)
//  1. ADD A=5 B=7 -> one cycle later ALUResult=12, Zero=0, done for 1 cycle. SUB A=7 B=7 -> 0, Zero=1.
//  2. MULTU A=0xFFFFFFFF B=2 -> busy 32 cycles; then Hi=1, Lo=ALUResult=0xFFFFFFFE, done pulse.
//  3. DIVU A=100 B=7 -> Lo=14, Hi=2, div_by_zero=0.
//     DIVU A=100 B=0 -> after 1 cycle div_by_zero=1, Lo=0xFFFFFFFF, Hi=100.
//  4. Start a MULTU. Pulse start with ADD mid-op -> ignored. Drive reset=0 at cycle 10 ->
//     next edge busy=0 and all outputs 0; a following MFHI returns 0.
//  5. MULTU 3*4, then DIVU 12/5 started in the done cycle -> accepted; Lo=12, then Lo=2, Hi=2.
//     MFLO -> ALUResult=2.
//  6. With ALU_SIGNED_MULDIV_EN: MULT A=-3 B=4 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF4, latency 33.
//     DIV A=-7 B=2 -> Lo=-3, Hi=-1.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Registered EX-stage ALU: 1-cycle logic/shift/add ops, iterative MULTU/DIVU with HI/LO.
// Define ALU_SIGNED_MULDIV_EN to add signed MULT/DIV with an extra sign-fix cycle.
module alu_muldiv_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         ALUOperation,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero,
  output logic [WIDTH-1:0]   Hi,
  output logic [WIDTH-1:0]   Lo,
  output logic               div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND   = 4'b0000, OP_OR    = 4'b0001, OP_NOR  = 4'b0010,
                         OP_ADD   = 4'b0011, OP_SLL   = 4'b0100, OP_SRL  = 4'b0101,
                         OP_ORI   = 4'b0111, OP_LUI   = 4'b1000, OP_SUB  = 4'b1001,
                         OP_MULTU = 4'b1010, OP_DIVU  = 4'b1011, OP_MFHI = 4'b1100,
                         OP_MFLO  = 4'b1101;

`ifdef ALU_SIGNED_MULDIV_EN
  localparam logic [3:0] OP_MULT = 4'b1110, OP_DIV = 4'b1111;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd;    // multiplicand or divisor
  logic [WIDTH-1:0] acc;     // product high half or partial remainder
  logic [WIDTH-1:0] lo_reg;  // multiplier or dividend, shifting into product low half / quotient

  logic [WIDTH-1:0] alu_res, mag_a, mag_b;
  logic             is_mul, is_div;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    alu_res = '0;
    case (ALUOperation)
      OP_AND:         alu_res = A & B;
      OP_OR, OP_ORI:  alu_res = A | B;
      OP_NOR:         alu_res = ~(A | B);
      OP_ADD:         alu_res = A + B;
      OP_SUB:         alu_res = A - B;
      OP_SLL:         alu_res = B << Shamt;
      OP_SRL:         alu_res = B >> Shamt;
      OP_LUI:         alu_res = B << (WIDTH / 2);
      OP_MFHI:        alu_res = Hi;
      OP_MFLO:        alu_res = Lo;
      default:        alu_res = '0;
    endcase
  end

  // One shift-add multiply step and one restoring-divide step, selected by state.
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH-1:0]     step_hi, step_lo, fin_hi, fin_lo;
  logic                 last, fin;

  assign mul_sum   = {1'b0, acc} + (lo_reg[0] ? {1'b0, opnd} : '0);
  assign mul_next  = {mul_sum, lo_reg[WIDTH-1:1]};
  assign div_shift = {acc, lo_reg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign step_hi   = (state == DIV) ? (div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0])
                                    : mul_next[2*WIDTH-1:WIDTH];
  assign step_lo   = (state == DIV) ? {lo_reg[WIDTH-2:0], ~div_diff[WIDTH]} : mul_next[WIDTH-1:0];
  assign last      = (cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state != IDLE);

`ifdef ALU_SIGNED_MULDIV_EN
  logic               is_signed, sgn_a, sgn_b;
  logic               sgn_op, op_div, neg_q, neg_r;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign is_signed = (ALUOperation == OP_MULT) || (ALUOperation == OP_DIV);
  assign sgn_a     = is_signed && A[WIDTH-1];
  assign sgn_b     = is_signed && B[WIDTH-1];
  assign mag_a     = sgn_a ? -A : A;
  assign mag_b     = sgn_b ? -B : B;
  assign is_mul    = (ALUOperation == OP_MULTU) || (ALUOperation == OP_MULT);
  assign is_div    = (ALUOperation == OP_DIVU) || (ALUOperation == OP_DIV);

  // Quotient/product take sign(A)^sign(B); remainder takes sign(A).
  assign prod_neg  = -{acc, lo_reg};
  assign fix_hi    = op_div ? (neg_r ? -acc : acc) : (neg_q ? prod_neg[2*WIDTH-1:WIDTH] : acc);
  assign fix_lo    = op_div ? (neg_q ? -lo_reg : lo_reg) : (neg_q ? prod_neg[WIDTH-1:0] : lo_reg);
  assign fin       = ((state == MUL || state == DIV) && last && !sgn_op) || (state == FIX);
  assign fin_hi    = (state == FIX) ? fix_hi : step_hi;
  assign fin_lo    = (state == FIX) ? fix_lo : step_lo;
`else
  assign mag_a     = A;
  assign mag_b     = B;
  assign is_mul    = (ALUOperation == OP_MULTU);
  assign is_div    = (ALUOperation == OP_DIVU);
  assign fin       = (state == MUL || state == DIV) && last;
  assign fin_hi    = step_hi;
  assign fin_lo    = step_lo;
`endif

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      opnd        <= '0;
      acc         <= '0;
      lo_reg      <= '0;
      done        <= 1'b0;
      ALUResult   <= '0;
      Zero        <= 1'b0;
      Hi          <= '0;
      Lo          <= '0;
      div_by_zero <= 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
      sgn_op      <= 1'b0;
      op_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt <= '0;
          acc <= '0;
          if (is_mul) begin
            opnd   <= mag_a;
            lo_reg <= mag_b;
            state  <= MUL;
          end else if (is_div && B == '0) begin
            Lo          <= '1;
            Hi          <= A;
            ALUResult   <= '1;
            Zero        <= 1'b0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
          end else if (is_div) begin
            opnd   <= mag_b;
            lo_reg <= mag_a;
            state  <= DIV;
          end else begin
            ALUResult   <= alu_res;
            Zero        <= (alu_res == '0);
            div_by_zero <= 1'b0;
            done        <= 1'b1;
          end
`ifdef ALU_SIGNED_MULDIV_EN
          sgn_op <= is_signed;
          op_div <= is_div;
          neg_q  <= sgn_a ^ sgn_b;
          neg_r  <= sgn_a;
`endif
        end
        MUL, DIV: begin
          acc    <= step_hi;
          lo_reg <= step_lo;
          cnt    <= cnt + 1'b1;
          if (last) begin
`ifdef ALU_SIGNED_MULDIV_EN
            state <= sgn_op ? FIX : IDLE;
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase

      if (fin) begin
        Hi          <= fin_hi;
        Lo          <= fin_lo;
        ALUResult   <= fin_lo;
        Zero        <= (fin_lo == '0);
        div_by_zero <= 1'b0;
        done        <= 1'b1;
      end
    end
  end

endmodule
